// File: rtl/ras_pkg.sv
// Shared types and constants for the return-address-stack controller.
package ras_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUSH,
        ST_POP,
        ST_CHECK,
        ST_FAULT,
        ST_CLEAR
    } ras_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE      = 2'b00,
        CAUSE_MISMATCH  = 2'b01,
        CAUSE_UNDERFLOW = 2'b10,
        CAUSE_OVERFLOW  = 2'b11
    } ras_cause_e;

    typedef enum logic [1:0] {
        NONE,
        CALL,
        RET,
        CORO
    } ras_kind_e;

    localparam logic [6:0] OPC_JAL  = 7'h6F;
    localparam logic [6:0] OPC_JALR = 7'h67;
    localparam logic [4:0] REG_RA   = 5'd1;
    localparam logic [4:0] REG_T0   = 5'd5;

    function automatic logic is_link(input logic [4:0] r);
        return (r == REG_RA) || (r == REG_T0);
    endfunction

endpackage

// File: rtl/ras_decode.sv
// Combinational classifier of RV32 JAL/JALR into call / return / coroutine.
module ras_decode
    import ras_pkg::*;
(
    input  logic [31:0] instr_i,
    output ras_kind_e   kind_o
);

    logic [6:0] opc;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic       rd_link;
    logic       rs1_link;
    logic       unused_bits;

    assign opc         = instr_i[6:0];
    assign rd          = instr_i[11:7];
    assign rs1         = instr_i[19:15];
    assign rd_link     = is_link(rd);
    assign rs1_link    = is_link(rs1);
    assign unused_bits = ^{instr_i[31:20], instr_i[14:12]};

    always_comb begin
        kind_o = NONE;
        if (opc == OPC_JAL) begin
            if (rd_link) kind_o = CALL;
        end else if (opc == OPC_JALR) begin
            // rd == rs1 == link register behaves as a plain call
            if (rd_link && rs1_link && (rd != rs1)) kind_o = CORO;
            else if (rd_link)                       kind_o = CALL;
            else if (rs1_link)                      kind_o = RET;
        end
    end

endmodule

// File: rtl/ras_ctrl.sv
// RAS sequencer: decodes calls/returns, drives the shadow stack, raises traps.
// Define RAS_OVF_TRACK_EN to absorb overflow with a counter instead of trapping.
module ras_ctrl
    import ras_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 512
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [31:0]           id_instr,
    input  logic [DATA_WIDTH-1:0] id_pc,
    input  logic [DATA_WIDTH-1:0] id_target,
    output logic                  id_ready,
    output logic                  stk_ena,
    output logic                  stk_push,
    output logic                  stk_pop,
    output logic                  stk_ret,
    output logic [DATA_WIDTH-1:0] stk_din,
    output logic                  stk_clr,
    input  logic                  stk_full,
    input  logic                  stk_empty,
    input  logic                  stk_mismatch,
    output logic                  fault_irq,
    output logic [1:0]            fault_cause,
    output logic [DATA_WIDTH-1:0] fault_pc,
    input  logic                  fault_ack
);

    ras_state_e            state_q, state_d;
    ras_kind_e             kind;
    ras_cause_e            cause_q, cause_d;
    logic                  ena_q, ena_d, push_q, push_d, pop_q, pop_d;
    logic                  ret_q, ret_d, clr_q, clr_d, irq_q, irq_d;
    logic                  coro_q, coro_d;
    logic [DATA_WIDTH-1:0] din_q, din_d, fpc_q, fpc_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d, link_q, link_d;
    logic                  ret_absorb;

    ras_decode u_decode (
        .instr_i (id_instr),
        .kind_o  (kind)
    );

`ifdef RAS_OVF_TRACK_EN
    localparam int OVF_W = $clog2(DEPTH) + 1;
    logic [OVF_W-1:0] ovf_cnt_q, ovf_cnt_d;

    always_ff @(posedge clk) begin
        if (rst) ovf_cnt_q <= '0;
        else     ovf_cnt_q <= ovf_cnt_d;
    end

    assign ret_absorb = (ovf_cnt_q != '0);
`else
    localparam int unused_depth = DEPTH;
    assign ret_absorb = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ena_d   = 1'b0;
        push_d  = 1'b0;
        pop_d   = 1'b0;
        ret_d   = 1'b0;
        clr_d   = 1'b0;
        din_d   = din_q;
        irq_d   = irq_q;
        cause_d = cause_q;
        fpc_d   = fpc_q;
        pc_d    = pc_q;
        link_d  = link_q;
        coro_d  = coro_q;
`ifdef RAS_OVF_TRACK_EN
        ovf_cnt_d = ovf_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (id_valid) begin
                    case (kind)
                        CALL: begin
                            if (!stk_full) begin
                                state_d = ST_PUSH;
                                ena_d   = 1'b1;
                                push_d  = 1'b1;
                                din_d   = id_pc + DATA_WIDTH'(4);
                            end else begin
`ifdef RAS_OVF_TRACK_EN
                                if (ovf_cnt_q != '1) ovf_cnt_d = ovf_cnt_q + OVF_W'(1);
`else
                                state_d = ST_FAULT;
                                irq_d   = 1'b1;
                                cause_d = CAUSE_OVERFLOW;
                                fpc_d   = id_pc;
`endif
                            end
                        end
                        RET, CORO: begin
                            coro_d = (kind == CORO);
                            pc_d   = id_pc;
                            link_d = id_pc + DATA_WIDTH'(4);
                            if (!stk_empty) begin
                                state_d = ST_POP;
                                ena_d   = 1'b1;
                                pop_d   = 1'b1;
                                ret_d   = 1'b1;
                                din_d   = id_target;
                            end else if (ret_absorb) begin
                                // entry was lost to overflow: nothing to check against
`ifdef RAS_OVF_TRACK_EN
                                ovf_cnt_d = ovf_cnt_q - OVF_W'(1);
`endif
                                if (kind == CORO) begin
                                    state_d = ST_PUSH;
                                    ena_d   = 1'b1;
                                    push_d  = 1'b1;
                                    din_d   = id_pc + DATA_WIDTH'(4);
                                end
                            end else begin
                                state_d = ST_FAULT;
                                irq_d   = 1'b1;
                                cause_d = CAUSE_UNDERFLOW;
                                fpc_d   = id_pc;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_PUSH: state_d = ST_IDLE;
            ST_POP:  state_d = ST_CHECK;
            ST_CHECK: begin
                if (stk_mismatch) begin
                    state_d = ST_FAULT;
                    irq_d   = 1'b1;
                    cause_d = CAUSE_MISMATCH;
                    fpc_d   = pc_q;
                end else if (coro_q) begin
                    state_d = ST_PUSH;
                    ena_d   = 1'b1;
                    push_d  = 1'b1;
                    din_d   = link_q;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FAULT: begin
                if (fault_ack) begin
                    state_d = ST_CLEAR;
                    clr_d   = 1'b1;
                    irq_d   = 1'b0;
                end
            end
            ST_CLEAR: begin
                state_d = ST_IDLE;
`ifdef RAS_OVF_TRACK_EN
                ovf_cnt_d = '0;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ena_q   <= 1'b0;
            push_q  <= 1'b0;
            pop_q   <= 1'b0;
            ret_q   <= 1'b0;
            clr_q   <= 1'b0;
            din_q   <= '0;
            irq_q   <= 1'b0;
            cause_q <= CAUSE_NONE;
            fpc_q   <= '0;
            pc_q    <= '0;
            link_q  <= '0;
            coro_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ena_q   <= ena_d;
            push_q  <= push_d;
            pop_q   <= pop_d;
            ret_q   <= ret_d;
            clr_q   <= clr_d;
            din_q   <= din_d;
            irq_q   <= irq_d;
            cause_q <= cause_d;
            fpc_q   <= fpc_d;
            pc_q    <= pc_d;
            link_q  <= link_d;
            coro_q  <= coro_d;
        end
    end

    assign id_ready    = (state_q == ST_IDLE) && !rst;
    assign stk_ena     = ena_q;
    assign stk_push    = push_q;
    assign stk_pop     = pop_q;
    assign stk_ret     = ret_q;
    assign stk_din     = din_q;
    assign stk_clr     = clr_q;
    assign fault_irq   = irq_q;
    assign fault_cause = cause_q;
    assign fault_pc    = fpc_q;

endmodule

// File: tb/tb_ras_ctrl.sv
// Directed testbench for ras_ctrl with a small behavioural shadow stack.
// Compile with RAS_OVF_TRACK_EN to exercise the overflow-counter variant.
module tb_ras_ctrl;

    localparam int DW    = 32;
    localparam int DEPTH = 8;

    localparam logic [31:0] I_JAL_RA   = 32'h0000_00EF; // jal x1, 0
    localparam logic [31:0] I_RET      = 32'h0000_8067; // jalr x0, 0(x1)
    localparam logic [31:0] I_CORO     = 32'h0000_82E7; // jalr x5, 0(x1)
    localparam logic [31:0] I_JALR_RA  = 32'h0000_80E7; // jalr x1, 0(x1)
    localparam logic [31:0] I_ADDI     = 32'h0000_0013; // nop

    logic          clk, rst;
    logic          id_valid, id_ready;
    logic [31:0]   id_instr;
    logic [DW-1:0] id_pc, id_target;
    logic          stk_ena, stk_push, stk_pop, stk_ret, stk_clr;
    logic [DW-1:0] stk_din;
    logic          stk_full, stk_empty, stk_mismatch;
    logic          fault_irq, fault_ack;
    logic [1:0]    fault_cause;
    logic [DW-1:0] fault_pc;

    int n_assert = 0;
    int n_fail   = 0;

    ras_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_instr     (id_instr),
        .id_pc        (id_pc),
        .id_target    (id_target),
        .id_ready     (id_ready),
        .stk_ena      (stk_ena),
        .stk_push     (stk_push),
        .stk_pop      (stk_pop),
        .stk_ret      (stk_ret),
        .stk_din      (stk_din),
        .stk_clr      (stk_clr),
        .stk_full     (stk_full),
        .stk_empty    (stk_empty),
        .stk_mismatch (stk_mismatch),
        .fault_irq    (fault_irq),
        .fault_cause  (fault_cause),
        .fault_pc     (fault_pc),
        .fault_ack    (fault_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural shadow stack with sticky mismatch
    logic [DW-1:0] mem [DEPTH];
    int            ptr;
    logic          mism;

    always @(posedge clk) begin
        if (rst || stk_clr) begin
            ptr  <= 0;
            mism <= 1'b0;
        end else if (stk_ena && stk_push) begin
            if (ptr < DEPTH) begin
                mem[ptr] <= stk_din;
                ptr      <= ptr + 1;
            end
        end else if (stk_ena && stk_pop && ptr > 0) begin
            ptr <= ptr - 1;
            if (stk_ret && mem[ptr-1] != stk_din) mism <= 1'b1;
        end
    end

    assign stk_full     = (ptr == DEPTH);
    assign stk_empty    = (ptr == 0);
    assign stk_mismatch = mism;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction, return in the cycle after acceptance
    task automatic send(input logic [31:0] instr, input logic [DW-1:0] pc, input logic [DW-1:0] tgt);
        int n = 0;
        id_valid  = 1'b1;
        id_instr  = instr;
        id_pc     = pc;
        id_target = tgt;
        while (!id_ready && n < 50) begin
            tick();
            n++;
        end
        check("accept_ready", id_ready, 1'b1);
        $display("txn instr=%08h pc=%08h target=%08h", instr, pc, tgt);
        tick();
        id_valid = 1'b0;
    endtask

    task automatic wait_irq(input string tag, output logic pop_seen);
        int n = 0;
        pop_seen = 1'b0;
        while (!fault_irq && n < 10) begin
            pop_seen |= stk_pop;
            tick();
            n++;
        end
        check(tag, fault_irq, 1'b1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!id_ready && n < 20) begin
            tick();
            n++;
        end
        check(tag, id_ready, 1'b1);
    endtask

    // Acknowledge in the current FAULT cycle, then expect one clear pulse
    task automatic ack_fault(input string tag);
        fault_ack = 1'b1;
        tick();
        fault_ack = 1'b0;
        check({tag, "_clr"}, stk_clr, 1'b1);
        check({tag, "_irq_low"}, fault_irq, 1'b0);
        check({tag, "_clr_ready"}, id_ready, 1'b0);
        tick();
        check({tag, "_clr_once"}, stk_clr, 1'b0);
        check({tag, "_idle"}, id_ready, 1'b1);
        check({tag, "_empty"}, stk_empty, 1'b1);
    endtask

    initial begin
        logic pop_seen;
        rst       = 1'b1;
        id_valid  = 1'b0;
        id_instr  = '0;
        id_pc     = '0;
        id_target = '0;
        fault_ack = 1'b0;
        repeat (3) tick();

        check("rst_ready", id_ready, 1'b0);
        check("rst_stk", {stk_ena, stk_push, stk_pop, stk_ret, stk_clr}, 5'b0);
        check("rst_din", stk_din, 0);
        check("rst_irq", fault_irq, 1'b0);
        check("rst_cause", fault_cause, 2'b00);
        check("rst_fpc", fault_pc, 0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", id_ready, 1'b1);

        // Plain call
        send(I_JAL_RA, 32'h100, 32'h0);
        check("call_push", {stk_ena, stk_push, stk_pop}, 3'b110);
        check("call_din", stk_din, 32'h104);
        check("call_busy", id_ready, 1'b0);
        tick();
        check("call_done", id_ready, 1'b1);
        check("call_push_once", stk_push, 1'b0);

        // Matching return
        send(I_RET, 32'h200, 32'h104);
        check("ret_pop", {stk_ena, stk_pop, stk_ret, stk_push}, 4'b1110);
        check("ret_din", stk_din, 32'h104);
        check("ret_busy_pop", id_ready, 1'b0);
        tick();
        check("ret_busy_check", id_ready, 1'b0);
        check("ret_pop_once", stk_pop, 1'b0);
        tick();
        check("ret_done", id_ready, 1'b1);
        check("ret_no_irq", fault_irq, 1'b0);
        check("ret_empty", stk_empty, 1'b1);

        // Mismatching return, acknowledged on the first FAULT cycle
        send(I_JAL_RA, 32'h100, 32'h0);
        tick();
        send(I_RET, 32'h300, 32'h200);
        tick();
        check("mm_check_no_irq", fault_irq, 1'b0);
        tick();
        check("mm_irq", fault_irq, 1'b1);
        check("mm_cause", fault_cause, 2'b01);
        check("mm_fpc", fault_pc, 32'h300);
        check("mm_ready", id_ready, 1'b0);
        ack_fault("mm");

        // Return on empty stack with nothing absorbed: underflow, no pop
        send(I_RET, 32'h400, 32'h123);
        wait_irq("uf_irq", pop_seen);
        check("uf_no_pop", pop_seen | stk_pop, 1'b0);
        check("uf_cause", fault_cause, 2'b10);
        check("uf_fpc", fault_pc, 32'h400);
        tick();
        check("uf_irq_held", fault_irq, 1'b1);
        ack_fault("uf");

        // Coroutine swap; an ack outside FAULT must not clear anything
        send(I_JAL_RA, 32'h100, 32'h0);
        tick();
        send(I_CORO, 32'h500, 32'h104);
        check("co_pop", {stk_pop, stk_ret, stk_push}, 3'b110);
        check("co_pop_din", stk_din, 32'h104);
        fault_ack = 1'b1;
        tick();
        fault_ack = 1'b0;
        check("co_check_ready", id_ready, 1'b0);
        check("co_check_nopush", stk_push, 1'b0);
        tick();
        check("co_push", {stk_ena, stk_push, stk_pop}, 3'b110);
        check("co_push_din", stk_din, 32'h504);
        check("co_stray_ack", stk_clr, 1'b0);
        check("co_push_ready", id_ready, 1'b0);
        tick();
        check("co_done", id_ready, 1'b1);
        check("co_no_irq", fault_irq, 1'b0);
        send(I_RET, 32'h600, 32'h504);
        tick();
        tick();
        check("co_ret_no_irq", fault_irq, 1'b0);
        check("co_ret_empty", stk_empty, 1'b1);

        // jalr x1,0(x1) is a call; a non-control instruction is ignored
        send(I_JALR_RA, 32'h700, 32'h888);
        check("jalr_call_push", stk_push, 1'b1);
        check("jalr_call_din", stk_din, 32'h704);
        tick();
        send(I_RET, 32'h710, 32'h704);
        tick();
        tick();
        id_valid = 1'b1;
        id_instr = I_ADDI;
        id_pc    = 32'h720;
        tick();
        id_valid = 1'b0;
        check("nop_ready", id_ready, 1'b1);
        check("nop_no_op", {stk_ena, fault_irq}, 2'b00);

        // Fill the stack, then one more call
        for (int i = 0; i < DEPTH; i++) begin
            send(I_JAL_RA, 32'h1000 + 32'(16 * i), 32'h0);
            tick();
        end
        check("fill_full", stk_full, 1'b1);
        send(I_JAL_RA, 32'h2000, 32'h0);
`ifdef RAS_OVF_TRACK_EN
        check("ovf_no_push", stk_push, 1'b0);
        check("ovf_ready", id_ready, 1'b1);
        check("ovf_no_irq", fault_irq, 1'b0);
        for (int i = DEPTH - 1; i >= 0; i--) begin
            send(I_RET, 32'h3000 + 32'(i), 32'h1004 + 32'(16 * i));
            tick();
            tick();
            check("drain_no_irq", fault_irq, 1'b0);
        end
        check("drain_empty", stk_empty, 1'b1);
        send(I_RET, 32'h4000, 32'h55);
        wait_idle("absorb_idle");
        tick();
        tick();
        check("absorb_no_irq", fault_irq, 1'b0);
        check("absorb_no_pop", stk_pop, 1'b0);
        send(I_RET, 32'h4100, 32'h55);
        wait_irq("uf2_irq", pop_seen);
        check("uf2_cause", fault_cause, 2'b10);
        check("uf2_fpc", fault_pc, 32'h4100);
        ack_fault("uf2");
`else
        wait_irq("ovf_irq", pop_seen);
        check("ovf_cause", fault_cause, 2'b11);
        check("ovf_fpc", fault_pc, 32'h2000);
        check("ovf_no_push", stk_push, 1'b0);
        ack_fault("ovf");
`endif

        // Reset during CHECK of a coroutine must suppress its push
        send(I_JAL_RA, 32'h100, 32'h0);
        tick();
        send(I_CORO, 32'h800, 32'h104);
        tick();
        rst = 1'b1;
        tick();
        check("rst_mid_nopush", {stk_ena, stk_push}, 2'b00);
        check("rst_mid_ready", id_ready, 1'b0);
        tick();
        check("rst_mid_nopush2", stk_push, 1'b0);
        rst = 1'b0;
        #1;
        check("rst_mid_idle", id_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ras_ctrl.md
# ras_ctrl

Sequencer for the return-address stack (RAS) shadow-stack hardware. Decodes call/return instructions from the decode stage and drives the stack's push/pop/return-check ports. Samples the stack's sticky mismatch flag and raises a trap request with cause and PC. After the trap is acknowledged, clears the stack before accepting further work. Sits between the ID stage and the RAS; stalls ID while a stack operation is in flight.

## Interface
- DATA_WIDTH, 32, width of PC / return address
- DEPTH, 512, entries in the attached stack; sets overflow-counter width (clog2(DEPTH)+1)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- id_valid  in  1  decode stage presents an instruction
- id_instr  in  32  RV32 instruction word
- id_pc  in  DATA_WIDTH  PC of id_instr
- id_target  in  DATA_WIDTH  resolved JALR target (rs1+imm, bit0 cleared)
- id_ready  out  1  controller accepts id_instr this cycle
- stk_ena, stk_push, stk_pop, stk_ret  out  1 each  stack controls (registered)
- stk_din  out  DATA_WIDTH  push data / return-compare value (registered)
- stk_clr  out  1  one-cycle stack clear; OR'd with rst at the stack
- stk_full, stk_empty, stk_mismatch  in  1 each  stack status
- fault_irq  out  1  trap request, level, held until acknowledged
- fault_cause  out  2  01 mismatch, 10 underflow, 11 overflow (macro off only)
- fault_pc  out  DATA_WIDTH  PC of the faulting return
- fault_ack  in  1  trap handler acknowledge

## Operation
- Classification: call = JAL (0x6F) or JALR (0x67) with rd∈{x1,x5}. Return = JALR with rs1∈{x1,x5} and rd∉{x1,x5}. Coroutine = JALR with rd,rs1∈{x1,x5} and rd≠rs1. JALR with rd=rs1∈{x1,x5} is a call. Everything else is ignored; id_ready stays 1.
- States: IDLE, PUSH, POP, CHECK, FAULT, CLEAR.
- IDLE: id_ready=1. On id_valid:
  - call → PUSH, stk_din=id_pc+4.
  - return → POP, stk_din=id_target, latch id_pc.
  - coroutine → POP, latch id_pc+4 for the later push.
- PUSH: stk_ena=stk_push=1 for one cycle → IDLE.
- POP: stk_ena=stk_pop=stk_ret=1 → CHECK. Exception: if stk_empty, issue no pop.
- CHECK: sample stk_mismatch.
  - 1 → FAULT, cause 01.
  - 0 → PUSH (coroutine) or IDLE.
- Empty on return, overflow counter 0 → FAULT, cause 10.
- FAULT: fault_irq=1, id_ready=0. fault_ack → CLEAR.
- CLEAR: stk_clr=1 one cycle; overflow counter←0; fault_irq←0 → IDLE.
- stk_push and stk_pop are never asserted together.

## Timing
- Reset values: id_ready=0 during rst, 1 in first cycle after. All stk_* outputs 0; stk_din 0. fault_irq 0, fault_cause 0, fault_pc 0. State IDLE; overflow counter 0.
- Call occupies 2 cycles (IDLE accept, PUSH). Stack updates at the end of PUSH.
- Return occupies 3 cycles. Mismatch is registered by the stack at the end of POP and sampled in CHECK. fault_irq is high in the cycle after CHECK.
- Coroutine occupies 4 cycles: IDLE, POP, CHECK, PUSH.
- id_ready=0 in every state except IDLE; ID must hold id_* stable until accepted.
- fault_ack in the same cycle FAULT is entered is honoured. fault_ack outside FAULT is ignored.
- rst mid-sequence aborts immediately: no partial stack op is issued after rst.

## Configuration
- RAS_OVF_TRACK_EN defined:
  - A call with stk_full skips the push and increments the overflow counter (saturating at 2^(clog2(DEPTH)+1)-1).
  - A return with stk_empty and counter>0 decrements the counter, passes unchecked, and goes to IDLE.
- Not defined: a call with stk_full → FAULT, cause 11, fault_pc=id_pc. No counter exists.

## Structure
- ras_pkg holds:
  - state enum ras_state_e and cause enum ras_cause_e;
  - opcode constants OPC_JAL/OPC_JALR and link-register indices;
  - the ras_kind_e enum {NONE, CALL, RET, CORO}.
- One sub-module, ras_decode: purely combinational, id_instr → ras_kind_e. Reused by the verification scoreboard.

## Test plan
- Reset then JAL x1 at pc 0x100 → stk_push=1 one cycle later with stk_din=0x104; id_ready low 1 cycle.
- Call at 0x100, then JALR x0,0(x1) target 0x104 → stk_pop/stk_ret pulse with stk_din=0x104; no fault; id_ready back after 3 cycles.
- Call at 0x100, then return with target 0x200 → fault_irq=1, cause 01, fault_pc=return PC. Then fault_ack → stk_clr pulse one cycle, state IDLE, stk_empty=1.
- Return on empty stack, counter 0 → cause 10; no stk_pop issued.
- Coroutine JALR x5,0(x1) after a call at 0x100 → pop checked against id_target, then push of id_pc+4; sequence takes 4 cycles.
- Fill stack to DEPTH, then one extra call:
  - macro on → counter=1, and the next return on empty passes silently;
  - macro off → cause 11.
